// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin bus arbiter.
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request after ptr, wrapping, ptr itself last.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest slot back to ptr+1 so the nearest hit is written last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for the shared 32-bit datapath: one-hot grant, mux select,
// and a per-burst beat limit with a one-cycle timeout pulse on forced hand-over.
//   state | meaning
//   IDLE  | no grant outstanding, searching from ptr+1
//   GRANT | sel_q owns the bus, cnt_q counts its beats
module bus_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  last,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             end_abandon;
    logic             end_last;
    logic             end_force;

    // While granted, the hand-over search starts just after the current winner.
    assign pick_ptr = (state_q == GRANT) ? sel_q : ptr_q;

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        end_abandon = 1'b0;
        end_last    = 1'b0;
        end_force   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                end_abandon = !req[sel_q];
                end_last    = req[sel_q] && last[sel_q];
                end_force   = !end_abandon && !end_last && (cnt_q == CNT_LAST);
                if (end_abandon || end_last || end_force) begin
                    ptr_d     = sel_q;
                    timeout_d = end_force;
                    cnt_d     = '0;
                    if (pick_any) begin
                        gnt_d = idx_to_onehot(pick_idx);
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd7;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/bus_arbiter8.md
# bus_arbiter8

Round-robin arbiter sharing one 32-bit datapath between eight requesters. Drives the 3-bit select of the 8:1 32-bit word mux plus a one-hot grant back to the requesters, and holds each grant for a bounded burst. Sits between the bridge/peripheral masters and the shared write-data/read-data path.

## Interface
- MAX_BEATS, 16: maximum granted cycles per burst (2..256).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  8  request per requester; bit i = requester i.
- last  in  8  final-beat flag; sampled only for the current winner.
- gnt  out  8  registered one-hot grant; all zero when idle.
- sel  out  3  registered binary index of granted requester; drives mux select.
- busy  out  1  registered; high while any gnt bit is high.
- timeout  out  1  registered one-cycle pulse when a burst is cut at MAX_BEATS.

## Operation
- State: IDLE, GRANT. Registers: ptr[2:0] (last winner), win[2:0], cnt (width clog2(MAX_BEATS+1)), gnt, sel, busy, timeout.
- Reset: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, cnt=0, ptr=7; the first search therefore starts at requester 0.
- Pick function: first set bit of req scanning ptr+1, ptr+2, ..., ptr+8 (mod 8). ptr itself is checked last.
- IDLE: if req != 0, win=pick, gnt=1<<win, sel=win, busy=1, cnt=0 -> GRANT. Else remain, outputs zero (sel holds its last value).
- GRANT, each cycle, end condition evaluated on the current winner w:
  - E1: req[w]=0 (abandon).
  - E2: req[w]=1 and last[w]=1 (normal end).
  - E3: cnt==MAX_BEATS-1 with neither E1 nor E2 (forced end); timeout=1 next cycle.
  - No end: cnt=cnt+1, outputs hold.
  - On end: ptr=w; re-pick over current req with ptr=w. If any req, grant new winner next cycle with cnt=0 (no idle gap, w eligible only if no other requester). If none, -> IDLE, gnt=0, busy=0.
- Priority among end conditions: E1 > E2 > E3. timeout asserts only for E3.
- Requests other than w are ignored while granted; requests never queue or latch.
- last for non-winners is ignored.

## Timing
- Request-to-grant latency: 1 cycle from IDLE (req sampled at edge N, gnt valid after edge N).
- Hand-over: zero dead cycles; gnt changes directly from one-hot old to one-hot new on the edge after the end cycle.
- Burst length: winner owns the bus for cnt+1 cycles, at most MAX_BEATS.
- gnt and sel always change on the same edge; gnt is never multi-hot; sel equals index of gnt whenever busy=1.
- timeout is high exactly one cycle, coincident with the first cycle of the following grant or IDLE.
- reset_n low at any point (mid-burst included): all outputs clear immediately, asynchronously; first grant after release follows reset rules (search from 0).

## Structure
- Shared package arb_pkg: NREQ=8, IDX_W=3, state enum {IDLE, GRANT}.
- One combinational sub-module rr_pick8: inputs req[7:0], ptr[2:0]; outputs any, idx[2:0]. Used for both IDLE pick and hand-over pick.
- Top holds FSM, counter and output registers.

## Test plan
- Reset then req=8'b1000_0001 held, last=0: first gnt=8'h01, sel=0; after 16 cycles timeout pulse, gnt=8'h80, sel=7.
- req=8'h0F, each winner asserts last on its 3rd granted cycle: grant order 0,1,2,3,0 with no gap cycles; each grant exactly 3 cycles.
- Winner 2 drops req on cycle 1 of grant, req=8'h24 otherwise: gnt moves to 8'h20 next cycle, timeout=0.
- Only requester 5 requesting, last asserted every 2nd cycle: gnt=8'h20 continuously, sel=5, busy never drops.
- req[w] and last[w] high with cnt==MAX_BEATS-1: normal end, timeout stays 0.
- reset_n pulsed low mid-burst with gnt=8'h08: gnt=0, busy=0, sel=0 immediately; after release with req=8'h88 first gnt=8'h08.
